claw_game_sequencer: RTL and testbench

//  Top-level game FSM of the claw machine. It owns one play cycle: coin/start, a timed joystick phase,

---
 rtl/claw_game_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_claw_game_sequencer.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/claw_game_sequencer.sv
// Purpose: top-level claw machine game FSM that runs one play cycle: start, timed joystick, drop, grip, lift, home, release.
// Latency: a panel press changes state 3 cycles after its falling edge (2-flop sync plus edge detect); every output is registered.
// Backpressure: none; this is a free-running control FSM, and presses that arrive outside the state that uses them are discarded.
// Ports: CLK100MHZ/rst_n are the clock and async active-low reset; start_n, drop_n, fwd, back, claw_up and home_n are
//   asynchronous panel and limit inputs; move_en/move_dir drive the stepper; drop_cmd/lift_cmd/grip_close drive the claw;
//   time_left holds the seconds left in PLAY, state_o the state code, game_over the end-of-game pulse, fault the fault flag.
module claw_game_sequencer #(
  parameter int TICK_DIV        = 100_000,
  parameter int GAME_SECONDS    = 30,
  parameter int DROP_MS         = 1500,
  parameter int GRIP_MS         = 500,
  parameter int LIFT_TIMEOUT_MS = 3000,
  parameter int HOME_TIMEOUT_MS = 8000,
  parameter int RELEASE_MS      = 1000
) (
  input  logic       CLK100MHZ,
  input  logic       rst_n,
  input  logic       start_n,
  input  logic       drop_n,
  input  logic       fwd,
  input  logic       back,
  input  logic       claw_up,
  input  logic       home_n,
  output logic       move_en,
  output logic       move_dir,
  output logic       drop_cmd,
  output logic       lift_cmd,
  output logic       grip_close,
  output logic [7:0] time_left,
  output logic [2:0] state_o,
  output logic       game_over,
  output logic       fault
);

  localparam int            TW           = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST    = TW'(TICK_DIV - 1);
  localparam logic [15:0]   MS_WRAP      = 16'd999;
  localparam logic [15:0]   DROP_LAST    = 16'(DROP_MS - 1);
  localparam logic [15:0]   GRIP_LAST    = 16'(GRIP_MS - 1);
  localparam logic [15:0]   LIFT_LAST    = 16'(LIFT_TIMEOUT_MS - 1);
  localparam logic [15:0]   HOME_LAST    = 16'(HOME_TIMEOUT_MS - 1);
  localparam logic [15:0]   RELEASE_LAST = 16'(RELEASE_MS - 1);
  localparam logic [7:0]    GAME_LOAD    = 8'(GAME_SECONDS);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PLAY    = 3'd1,
    S_DROP    = 3'd2,
    S_GRIP    = 3'd3,
    S_LIFT    = 3'd4,
    S_HOME    = 3'd5,
    S_RELEASE = 3'd6,
    S_FAULT   = 3'd7
  } state_t;

  state_t state, state_nxt;

  // Synchronisers. The button chains carry one extra flop: it holds the
  // previous synchronised level, which the falling-edge detector needs.
  logic [2:0] start_sync, drop_sync;
  logic [1:0] fwd_sync, back_sync, up_sync, home_sync;
  logic       start_edge, drop_edge;
  logic       fwd_s, back_s, up_s, home_s;

  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      start_sync <= '0;
      drop_sync  <= '0;
      fwd_sync   <= '0;
      back_sync  <= '0;
      up_sync    <= '0;
      home_sync  <= '0;
    end else begin
      start_sync <= {start_sync[1:0], start_n};
      drop_sync  <= {drop_sync[1:0], drop_n};
      fwd_sync   <= {fwd_sync[0], fwd};
      back_sync  <= {back_sync[0], back};
      up_sync    <= {up_sync[0], claw_up};
      home_sync  <= {home_sync[0], home_n};
    end
  end

  assign start_edge = start_sync[2] & ~start_sync[1];
  assign drop_edge  = drop_sync[2] & ~drop_sync[1];
  assign fwd_s      = fwd_sync[1];
  assign back_s     = back_sync[1];
  assign up_s       = up_sync[1];
  assign home_s     = home_sync[1];

  // Millisecond timebase. Both counters restart on every state change, so
  // "tick && phase_ms == D-1" marks exactly D*TICK_DIV cycles in the phase.
  logic [TW-1:0] tick_cnt;
  logic [15:0]   phase_ms;
  logic          tick, sec_wrap;

  assign tick     = (tick_cnt == TICK_LAST);
  assign sec_wrap = (state == S_PLAY) && tick && (phase_ms == MS_WRAP);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start_edge) state_nxt = S_PLAY;
      // A drop press and the last second expiring on the same edge both
      // point at DROP, so the phase is entered only once.
      S_PLAY:    if (drop_edge || (sec_wrap && time_left == 8'd1)) state_nxt = S_DROP;
      S_DROP:    if (tick && phase_ms == DROP_LAST) state_nxt = S_GRIP;
      S_GRIP:    if (tick && phase_ms == GRIP_LAST) state_nxt = S_LIFT;
      // The limit switch is tested first, so a claw_up that arrives on the timeout edge wins.
      S_LIFT: begin
        if (up_s)                                state_nxt = S_HOME;
        else if (tick && phase_ms == LIFT_LAST)  state_nxt = S_FAULT;
      end
      S_HOME: begin
        if (!home_s)                             state_nxt = S_RELEASE;
        else if (tick && phase_ms == HOME_LAST)  state_nxt = S_FAULT;
      end
      S_RELEASE: if (tick && phase_ms == RELEASE_LAST) state_nxt = S_IDLE;
      S_FAULT:   if (start_edge) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Output values are decoded from the next state, so each registered output
  // changes on the same edge as the state it belongs to.
  logic       move_en_d, move_dir_d, drop_cmd_d, lift_cmd_d, grip_close_d;
  logic       game_over_d, fault_d;
  logic [7:0] time_left_d;

  always_comb begin
    move_en_d    = 1'b0;
    move_dir_d   = 1'b0;
    drop_cmd_d   = 1'b0;
    lift_cmd_d   = 1'b0;
    grip_close_d = 1'b0;
    fault_d      = 1'b0;
    game_over_d  = (state == S_RELEASE) && (state_nxt == S_IDLE);
    case (state_nxt)
      S_PLAY: begin
        // Moving backward is blocked once the carriage sits on its home stopper.
        move_en_d  = (fwd_s ^ back_s) & ~(back_s & ~home_s);
        move_dir_d = fwd_s;
      end
      S_DROP:  drop_cmd_d = 1'b1;
      S_GRIP:  grip_close_d = 1'b1;
      S_LIFT: begin
        lift_cmd_d   = 1'b1;
        grip_close_d = 1'b1;
      end
      S_HOME: begin
        move_en_d    = 1'b1;
        grip_close_d = 1'b1;
      end
      S_FAULT: fault_d = 1'b1;
      default: ;
    endcase

    if (state == S_IDLE && state_nxt == S_PLAY) time_left_d = GAME_LOAD;
    else if (state_nxt == S_IDLE)               time_left_d = 8'd0;
    else if (sec_wrap)                          time_left_d = time_left - 8'd1;
    else                                        time_left_d = time_left;
  end

  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      tick_cnt   <= '0;
      phase_ms   <= '0;
      move_en    <= 1'b0;
      move_dir   <= 1'b0;
      drop_cmd   <= 1'b0;
      lift_cmd   <= 1'b0;
      grip_close <= 1'b0;
      time_left  <= 8'd0;
      game_over  <= 1'b0;
      fault      <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) begin
        tick_cnt <= '0;
        phase_ms <= '0;
      end else if (tick) begin
        tick_cnt <= '0;
        phase_ms <= sec_wrap ? 16'd0 : phase_ms + 16'd1;
      end else begin
        tick_cnt <= tick_cnt + TW'(1);
      end
      move_en    <= move_en_d;
      move_dir   <= move_dir_d;
      drop_cmd   <= drop_cmd_d;
      lift_cmd   <= lift_cmd_d;
      grip_close <= grip_close_d;
      time_left  <= time_left_d;
      game_over  <= game_over_d;
      fault      <= fault_d;
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_claw_game_sequencer.sv
// Purpose: self-checking bench for claw_game_sequencer, using an elapsed-time reference model plus directed timing checks.
// Latency: the model predicts every registered output for every cycle, and a negedge process compares it against the DUT.
// Backpressure: not applicable; the bench drives inputs on the falling clock edge.
module tb_claw_game_sequencer;

  localparam int TD      = 10;
  localparam int GS      = 3;
  localparam int DROP_MS = 4;
  localparam int GRIP_MS = 2;
  localparam int LIFT_MS = 5;
  localparam int HOME_MS = 6;
  localparam int REL_MS  = 3;
  localparam int SEC     = 1000 * TD;

  localparam int ST_IDLE = 0, ST_PLAY = 1, ST_DROP = 2, ST_GRIP = 3;
  localparam int ST_LIFT = 4, ST_HOME = 5, ST_REL  = 6, ST_FAULT = 7;

  logic       CLK100MHZ = 1'b0;
  logic       rst_n     = 1'b0;
  logic       start_n   = 1'b1;
  logic       drop_n    = 1'b1;
  logic       fwd       = 1'b0;
  logic       back      = 1'b0;
  logic       claw_up   = 1'b0;
  logic       home_n    = 1'b1;
  logic       move_en, move_dir, drop_cmd, lift_cmd, grip_close, game_over, fault;
  logic [7:0] time_left;
  logic [2:0] state_o;

  claw_game_sequencer #(
    .TICK_DIV(TD), .GAME_SECONDS(GS), .DROP_MS(DROP_MS), .GRIP_MS(GRIP_MS),
    .LIFT_TIMEOUT_MS(LIFT_MS), .HOME_TIMEOUT_MS(HOME_MS), .RELEASE_MS(REL_MS)
  ) dut (
    .CLK100MHZ(CLK100MHZ), .rst_n(rst_n), .start_n(start_n), .drop_n(drop_n),
    .fwd(fwd), .back(back), .claw_up(claw_up), .home_n(home_n),
    .move_en(move_en), .move_dir(move_dir), .drop_cmd(drop_cmd), .lift_cmd(lift_cmd),
    .grip_close(grip_close), .time_left(time_left), .state_o(state_o),
    .game_over(game_over), .fault(fault)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model. An input sampled on edge n acts on edge n+2 (n+3 for the
  // previous level of a button), so short input histories stand in for the
  // synchronisers. Phases are timed by counting elapsed cycles since entry.
  int         m_st  = ST_IDLE;
  int         m_cyc = 0;
  int         m_tl  = 0;
  int         c, nxt;
  logic [2:0] h_start = '0, h_drop = '0;
  logic [1:0] h_fwd = '0, h_back = '0, h_up = '0, h_home = '0;
  logic       start_ev, drop_ev, f, b, u, h, go, sec;
  logic       me, md, dc, lc, gc, fl;
  logic [17:0] m_out = '0;
  logic [17:0] dut_out;
  logic        run_chk = 1'b0;

  assign dut_out = {state_o, time_left, move_en, move_dir, drop_cmd, lift_cmd, grip_close, game_over, fault};

  always @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      m_st = ST_IDLE; m_cyc = 0; m_tl = 0; m_out = '0;
      h_start = '0; h_drop = '0; h_fwd = '0; h_back = '0; h_up = '0; h_home = '0;
    end else begin
      start_ev = h_start[2] & ~h_start[1];
      drop_ev  = h_drop[2] & ~h_drop[1];
      f = h_fwd[1]; b = h_back[1]; u = h_up[1]; h = h_home[1];
      c   = m_cyc + 1;
      nxt = m_st;
      go  = 1'b0;
      case (m_st)
        ST_IDLE: if (start_ev) begin nxt = ST_PLAY; m_tl = GS; end
        ST_PLAY: begin
          sec = (c % SEC == 0);
          if (sec) m_tl = m_tl - 1;
          if (drop_ev || (sec && m_tl == 0)) nxt = ST_DROP;
        end
        ST_DROP: if (c == DROP_MS * TD) nxt = ST_GRIP;
        ST_GRIP: if (c == GRIP_MS * TD) nxt = ST_LIFT;
        ST_LIFT: if (u) nxt = ST_HOME; else if (c == LIFT_MS * TD) nxt = ST_FAULT;
        ST_HOME: if (!h) nxt = ST_REL; else if (c == HOME_MS * TD) nxt = ST_FAULT;
        ST_REL:  if (c == REL_MS * TD) begin nxt = ST_IDLE; go = 1'b1; end
        default: if (start_ev) nxt = ST_IDLE;
      endcase
      if (nxt == ST_IDLE) m_tl = 0;
      m_cyc = (nxt == m_st) ? c : 0;
      m_st  = nxt;
      me = 0; md = 0; dc = 0; lc = 0; gc = 0; fl = 0;
      case (m_st)
        ST_PLAY: begin me = (f ^ b) & ~(b & ~h); md = f; end
        ST_DROP: dc = 1;
        ST_GRIP: gc = 1;
        ST_LIFT: begin lc = 1; gc = 1; end
        ST_HOME: begin me = 1; gc = 1; end
        ST_FAULT: fl = 1;
        default: ;
      endcase
      m_out = {3'(m_st), 8'(m_tl), me, md, dc, lc, gc, go, fl};
      h_start = {h_start[1:0], start_n};
      h_drop  = {h_drop[1:0], drop_n};
      h_fwd   = {h_fwd[0], fwd};
      h_back  = {h_back[0], back};
      h_up    = {h_up[0], claw_up};
      h_home  = {h_home[0], home_n};
    end
  end

  always @(negedge CLK100MHZ)
    if (rst_n && run_chk) chk("cycle_outputs", 32'(dut_out), 32'(m_out));

  task automatic step(input int n);
    repeat (n) @(negedge CLK100MHZ);
  endtask

  task automatic wait_state(input string tag, input int s, input int limit, output int waited);
    waited = 0;
    while (state_o !== 3'(s) && waited < limit) begin
      @(negedge CLK100MHZ);
      waited++;
    end
    if (state_o !== 3'(s)) chk(tag, 32'(state_o), 32'(s));
  endtask

  task automatic state_len(input int s, input int limit, output int len);
    len = 0;
    while (state_o === 3'(s) && len < limit) begin
      @(negedge CLK100MHZ);
      len++;
    end
  endtask

  task automatic press_start();
    start_n = 1'b0;
    step(5);
    start_n = 1'b1;
  endtask

  task automatic press_drop();
    drop_n = 1'b0;
    step(5);
    drop_n = 1'b1;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, len, n;
    step(3);
    chk("reset_outputs", 32'(dut_out), 32'd0);
    rst_n   = 1'b1;
    run_chk = 1'b1;
    step(4);
    chk("idle_outputs", 32'(dut_out), 32'd0);

    // Game 1: start latency, joystick rules, seconds countdown, timeout into DROP, LIFT timeout into FAULT.
    start_n = 1'b0;
    step(2);
    chk("start_lat_2", 32'(state_o), ST_IDLE);
    step(1);
    chk("start_lat_3", 32'(state_o), ST_PLAY);
    chk("time_left_load", 32'(time_left), GS);
    step(2);
    start_n = 1'b1;
    for (int k = 3; k <= 30000; k++) begin
      step(1);
      if (k == 100) begin fwd = 1; back = 0; home_n = 1; end
      if (k == 104) chk("joy_fwd", 32'({move_en, move_dir}), 32'b11);
      if (k == 105) begin fwd = 1; back = 1; end
      if (k == 110) chk("joy_both", 32'(move_en), 0);
      if (k == 110) begin fwd = 0; back = 1; home_n = 0; end
      if (k == 115) chk("joy_back_home", 32'(move_en), 0);
      if (k == 115) home_n = 1;
      if (k == 120) chk("joy_back", 32'({move_en, move_dir}), 32'b10);
      if (k > 120 && k < 29900 && (k % 37 == 0)) {fwd, back, home_n} = 3'($urandom);
      if (k == 29900) begin fwd = 0; back = 0; home_n = 1; end
      if (k == 9999)  chk("time_left_9999", 32'(time_left), 3);
      if (k == 10000) chk("time_left_10000", 32'(time_left), 2);
      if (k == 29999) chk("play_before_timeout", 32'(state_o), ST_PLAY);
      if (k == 30000) chk("timeout_to_drop", 32'({state_o, time_left}), 32'({3'(ST_DROP), 8'd0}));
    end
    state_len(ST_DROP, 200, len);
    chk("drop_len_timeout", 32'(len), DROP_MS * TD);
    state_len(ST_GRIP, 200, len);
    chk("grip_len", 32'(len), GRIP_MS * TD);
    state_len(ST_LIFT, 200, len);
    chk("lift_timeout_len", 32'(len), LIFT_MS * TD);
    chk("fault_outputs", 32'({state_o, move_en, drop_cmd, lift_cmd, grip_close, fault}),
        32'({3'(ST_FAULT), 5'b00001}));
    start_n = 1'b0;
    step(3);
    chk("fault_to_idle", 32'(state_o), ST_IDLE);
    step(2);
    start_n = 1'b1;
    step(3);
    chk("fault_exit_not_play", 32'(state_o), ST_IDLE);
    press_drop();
    step(3);
    chk("drop_ignored_in_idle", 32'(state_o), ST_IDLE);

    // Game 2: full cycle through a drop press, with a start press during DROP that must be ignored.
    press_start();
    wait_state("g2_play", ST_PLAY, 10, w);
    n = $urandom_range(400, 60);
    repeat (n) begin
      step(1);
      {fwd, back, home_n} = 3'($urandom);
    end
    fwd = 0; back = 0; home_n = 1;
    drop_n = 1'b0;
    step(3);
    chk("drop_press_lat", 32'(state_o), ST_DROP);
    step(2);
    drop_n = 1'b1;
    press_start();
    state_len(ST_DROP, 200, len);
    chk("drop_len_press", 32'(7 + len), DROP_MS * TD);
    state_len(ST_GRIP, 200, len);
    chk("grip_len_2", 32'(len), GRIP_MS * TD);
    step(12);
    claw_up = 1'b1;
    state_len(ST_LIFT, 200, len);
    chk("lift_len_up", 32'(12 + len), 15);
    chk("home_outputs", 32'({state_o, move_en, move_dir, grip_close, lift_cmd}),
        32'({3'(ST_HOME), 4'b1010}));
    step(1);
    claw_up = 1'b0;
    step(4);
    home_n = 1'b0;
    wait_state("g2_release", ST_REL, 10, w);
    chk("home_stop_lat", 32'(w), 3);
    chk("release_outputs", 32'({move_en, grip_close, lift_cmd, drop_cmd}), 0);
    state_len(ST_REL, 200, len);
    chk("release_len", 32'(len), REL_MS * TD);
    chk("game_over_pulse", 32'({state_o, game_over}), 32'({3'(ST_IDLE), 1'b1}));
    step(1);
    chk("game_over_clear", 32'(game_over), 0);
    home_n = 1'b1;

    // Game 3: drop press landing on the same edge the last second expires; claw up and home already reached on entry.
    start_n = 1'b0;
    step(3);
    chk("g3_play", 32'(state_o), ST_PLAY);
    for (int k = 1; k <= 30000; k++) begin
      step(1);
      if (k == 2) start_n = 1'b1;
      if (k == 29997) drop_n = 1'b0;
      if (k == 29999) chk("g3_play_last", 32'(state_o), ST_PLAY);
      if (k == 30000) chk("g3_coincide_drop", 32'({state_o, time_left}), 32'({3'(ST_DROP), 8'd0}));
    end
    step(2);
    drop_n = 1'b1;
    state_len(ST_DROP, 200, len);
    chk("drop_len_coincide", 32'(2 + len), DROP_MS * TD);
    claw_up = 1'b1;
    home_n  = 1'b0;
    state_len(ST_GRIP, 200, len);
    state_len(ST_LIFT, 200, len);
    chk("lift_len_up_early", 32'(len), 1);
    state_len(ST_HOME, 200, len);
    chk("home_len_at_home", 32'(len), 1);
    wait_state("g3_idle", ST_IDLE, 100, w);
    claw_up = 1'b0;
    home_n  = 1'b1;

    // Game 4: asynchronous reset in the middle of HOME.
    press_start();
    press_drop();
    wait_state("g4_lift", ST_LIFT, 200, w);
    claw_up = 1'b1;
    wait_state("g4_home", ST_HOME, 10, w);
    step(10);
    chk("pre_reset_home", 32'({move_en, grip_close, state_o}), 32'({2'b11, 3'(ST_HOME)}));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", 32'({move_en, grip_close, state_o}), 0);
    chk("async_reset_all", 32'(dut_out), 0);
    step(2);
    rst_n   = 1'b1;
    claw_up = 1'b0;
    step(3);
    chk("after_reset_idle", 32'(state_o), ST_IDLE);

    // Game 5: home limit never reached, so HOME times out into FAULT.
    claw_up = 1'b1;
    press_start();
    press_drop();
    wait_state("g5_home", ST_HOME, 200, w);
    state_len(ST_HOME, 200, len);
    chk("home_timeout_len", 32'(len), HOME_MS * TD);
    chk("home_timeout_fault", 32'({state_o, fault, move_en}), 32'({3'(ST_FAULT), 2'b10}));
    claw_up = 1'b0;
    press_start();
    wait_state("g5_idle", ST_IDLE, 10, w);
    step(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
